// File: rtl/glitch_pulse_gen.sv
// Trigger-driven glitch pulse-train generator: synchronises the target trigger,
// waits a programmed delay, then emits N pulses of programmed width and spacing.
module glitch_pulse_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger_i,
  input  logic        arm_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] spacing_i,
  output logic        pulse_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   trig_prev_q, trig_prev_d;
  logic                   edge_q, edge_d;
  logic                   arm_q, arm_d;
  logic [15:0]            delay_q, delay_d;
  logic [7:0]             width_q, width_d;
  logic [15:0]            spacing_q, spacing_d;
  logic [7:0]             left_q, left_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   arm_req;

  // Counters hold "cycles remaining minus one" so a zero test ends each phase.
  function automatic logic [15:0] width_reload(input logic [7:0] w);
    return {8'd0, w} - 16'd1;
  endfunction

  function automatic logic [15:0] gap_reload(input logic [15:0] s);
    return (s == 16'd0) ? 16'd0 : s - 16'd1;
  endfunction

  assign arm_req = arm_i & ~arm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      edge_q      <= 1'b0;
      arm_q       <= 1'b0;
      delay_q     <= '0;
      width_q     <= '0;
      spacing_q   <= '0;
      left_q      <= '0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      trig_prev_q <= trig_prev_d;
      edge_q      <= edge_d;
      arm_q       <= arm_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      spacing_q   <= spacing_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], trigger_i};
    trig_prev_d = sync_q[SYNC_STAGES-1];
    // Edge is registered once more; together with the delay counter this
    // places the first rise exactly delay cycles after the ARMED->DELAY hop.
    edge_d      = sync_q[SYNC_STAGES-1] & ~trig_prev_q;
    arm_d       = arm_i;
    delay_d     = delay_q;
    width_d     = width_q;
    spacing_d   = spacing_q;
    left_d      = left_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (arm_req && (width_i != 8'd0) && (num_pulses_i != 8'd0)) begin
          delay_d   = delay_i;
          width_d   = width_i;
          spacing_d = spacing_i;
          left_d    = num_pulses_i;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (edge_q) begin
          if (delay_q == 16'd0) begin
            state_d = PULSE;
            cnt_d   = width_reload(width_q);
          end else begin
            state_d = DELAY;
            cnt_d   = delay_q - 16'd1;
          end
        end
      end
      DELAY: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (cnt_q == 16'd0) begin
          state_d = PULSE;
          cnt_d   = width_reload(width_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PULSE: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (cnt_q == 16'd0) begin
          left_d = left_q - 8'd1;
          if (left_q > 8'd1) begin
            state_d = GAP;
            cnt_d   = gap_reload(spacing_q);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (!arm_i) begin
          state_d = IDLE;
        end else if (cnt_q == 16'd0) begin
          state_d = PULSE;
          cnt_d   = width_reload(width_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state into dedicated flops so the pin
  // never sees state-decode glitches.
  always_comb begin
    pulse_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == PULSE) && arm_i && (cnt_q == 16'd0) && (left_q == 8'd1);
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: per-cycle expectations of pulse/done/busy
// are queued from the timing model when a trigger is driven and popped each cycle.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_i;
  logic        arm_i;
  logic [15:0] delay_i;
  logic [7:0]  width_i;
  logic [7:0]  num_pulses_i;
  logic [15:0] spacing_i;
  logic        pulse_o;
  logic        busy_o;
  logic        done_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic p;
    logic d;
    logic b;
  } exp_t;

  exp_t exp_q[$];

  glitch_pulse_gen #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger_i    (trigger_i),
    .arm_i        (arm_i),
    .delay_i      (delay_i),
    .width_i      (width_i),
    .num_pulses_i (num_pulses_i),
    .spacing_i    (spacing_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input int m, input logic got, input logic want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s m=%0d: got %b want %b", name, m, got, want);
  endtask

  // Arm with the given parameters; afterwards scramble the inputs so only the
  // latched copy can produce the expected train.
  task automatic arm(input int d, input int w, input int n, input int s, input logic exp_busy);
    delay_i      = 16'(d);
    width_i      = 8'(w);
    num_pulses_i = 8'(n);
    spacing_i    = 16'(s);
    arm_i        = 1'b1;
    step();
    check("arm_busy", 0, busy_o, exp_busy);
    delay_i      = 16'($urandom);
    width_i      = 8'($urandom);
    num_pulses_i = 8'($urandom);
    spacing_i    = 16'($urandom);
  endtask

  // m = edges after the one at which trigger_i is first sampled high.
  task automatic push_train(input int d, input int w, input int n, input int s,
                            input int first, input int last);
    int g, r0, period, fin;
    exp_t e;
    g      = (s == 0) ? 1 : s;
    r0     = 3 + d;
    period = w + g;
    fin    = r0 + (n - 1) * period + w;
    for (int m = first; m <= last; m++) begin
      e.p = 1'b0;
      for (int i = 0; i < n; i++)
        if (m >= r0 + i * period && m < r0 + i * period + w) e.p = 1'b1;
      e.d = (m == fin);
      e.b = (m < fin);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(input logic p, input logic d, input logic b, input int count);
    exp_t e;
    e.p = p;
    e.d = d;
    e.b = b;
    for (int i = 0; i < count; i++) exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int tog_from);
    exp_t e;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check({tag, "_pulse"}, idx, pulse_o, e.p);
      check({tag, "_done"},  idx, done_o,  e.d);
      check({tag, "_busy"},  idx, busy_o,  e.b);
      if (tog_from >= 0 && idx >= tog_from) trigger_i = ~trigger_i;
      idx++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    trigger_i    = 1'b0;
    arm_i        = 1'b0;
    delay_i      = '0;
    width_i      = '0;
    num_pulses_i = '0;
    spacing_i    = '0;
    idle(2);
    check("rst_pulse", 0, pulse_o, 1'b0);
    check("rst_busy",  0, busy_o,  1'b0);
    check("rst_done",  0, done_o,  1'b0);
    rst = 1'b0;
    idle(2);

    // Single pulse after delay 10, then a second trigger without re-arm.
    arm(10, 4, 1, 0, 1'b1);
    idle(3);
    trigger_i = 1'b1;
    push_train(10, 4, 1, 0, 0, 20);
    drain("t1", -1);
    trigger_i = 1'b0;
    idle(3);
    trigger_i = 1'b1;
    push_const(1'b0, 1'b0, 1'b0, 10);
    drain("t1_norearm", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);

    // Zero delay, three pulses.
    arm(0, 2, 3, 5, 1'b1);
    idle(2);
    trigger_i = 1'b1;
    push_train(0, 2, 3, 5, 0, 22);
    drain("t2", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);

    // Spacing 0 still separates single-cycle pulses.
    arm(3, 1, 4, 0, 1'b1);
    idle(2);
    trigger_i = 1'b1;
    push_train(3, 1, 4, 0, 0, 16);
    drain("t3", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);

    // Width 0 and N 0 are rejected.
    arm(5, 0, 3, 2, 1'b0);
    idle(1);
    trigger_i = 1'b1;
    push_const(1'b0, 1'b0, 1'b0, 10);
    drain("t4_w0", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);
    arm(5, 3, 0, 2, 1'b0);
    idle(1);
    trigger_i = 1'b1;
    push_const(1'b0, 1'b0, 1'b0, 10);
    drain("t4_n0", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);

    // Abort during the second of five pulses.
    arm(2, 3, 5, 2, 1'b1);
    idle(2);
    trigger_i = 1'b1;
    push_train(2, 3, 5, 2, 0, 10);
    drain("t5_run", -1);
    arm_i = 1'b0;
    push_const(1'b0, 1'b0, 1'b0, 10);
    drain("t5_abort", -1);
    trigger_i = 1'b0;
    idle(2);
    trigger_i = 1'b1;
    push_const(1'b0, 1'b0, 1'b0, 10);
    drain("t5_noarm", -1);
    trigger_i = 1'b0;
    idle(2);

    // Trigger already high at arm time; extra edges during the train.
    trigger_i = 1'b1;
    idle(4);
    arm(1, 2, 2, 1, 1'b1);
    push_const(1'b0, 1'b0, 1'b1, 8);
    drain("t6_high", -1);
    trigger_i = 1'b0;
    push_const(1'b0, 1'b0, 1'b1, 4);
    drain("t6_low", -1);
    trigger_i = 1'b1;
    push_train(1, 2, 2, 1, 0, 16);
    drain("t6_train", 3);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(3);

    // Asynchronous reset in the middle of a pulse.
    arm(0, 8, 1, 0, 1'b1);
    idle(2);
    trigger_i = 1'b1;
    push_train(0, 8, 1, 0, 0, 5);
    drain("t7_run", -1);
    rst = 1'b1;
    #1;
    check("t7_rst_pulse", 0, pulse_o, 1'b0);
    check("t7_rst_busy",  0, busy_o,  1'b0);
    check("t7_rst_done",  0, done_o,  1'b0);
    idle(2);
    check("t7_hold_pulse", 1, pulse_o, 1'b0);
    rst       = 1'b0;
    arm_i     = 1'b0;
    trigger_i = 1'b0;
    idle(2);

    // Normal operation resumes after reset.
    arm(0, 2, 2, 0, 1'b1);
    idle(2);
    trigger_i = 1'b1;
    push_train(0, 2, 2, 0, 0, 10);
    drain("t8", -1);
    trigger_i = 1'b0;
    arm_i = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Trigger-driven pulse-train generator that turns the glitch parameters produced by the UART command handler (delay, width, pulse count, spacing, enable) into the physical `pulse_o` glitch output. It sits in `glitch_control` between `uart_handler` and the `pulse_o` pin. The block synchronises the external target trigger, waits a programmed delay, then emits a programmed number of pulses of programmed width and spacing.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `trigger_i`; minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `trigger_i`  in  1  target trigger, asynchronous to `clk`; rising edge starts the sequence
- `arm_i`  in  1  enable level from the command handler (`pulse_en`)
- `delay_i`  in  16  cycles from detected trigger edge to first pulse
- `width_i`  in  8  pulse high time, cycles
- `num_pulses_i`  in  8  pulses per trigger
- `spacing_i`  in  16  low time between pulses, cycles
- `pulse_o`  out  1  glitch pulse, registered, glitch-free
- `busy_o`  out  1  high while armed or sequencing
- `done_o`  out  1  one-cycle strobe when a train completes normally

## Operation
- Reset: state IDLE; `pulse_o`, `busy_o`, `done_o`, all counters and synchroniser/edge flops = 0.
- `arm_i` is registered into `arm_q`; arm request = `arm_i & ~arm_q` (rising edge).
- States: IDLE, ARMED, DELAY, PULSE, GAP.
- IDLE: on arm request with `width_i != 0` and `num_pulses_i != 0`, latch all four parameters and go to ARMED. Otherwise the request is ignored and the block stays in IDLE.
- Latched parameters are used for the whole sequence. Input changes mid-sequence have no effect.
- ARMED: wait for a trigger edge: synchroniser output high and its previous value low. Edges detected in any other state are ignored. On an edge go to DELAY. Delay 0 skips straight to PULSE so the timing below holds.
- DELAY: count `delay` cycles, then go to PULSE.
- PULSE: `pulse_o` high for exactly `width` cycles. Decrement the remaining-pulse count. If pulses remain go to GAP, else go to IDLE with `done_o`.
- GAP: `pulse_o` low for exactly max(`spacing`, 1) cycles, then go to PULSE. Spacing 0 therefore still gives one low cycle between pulses.
- Abort: `arm_i` = 0 in ARMED, DELAY, PULSE or GAP. Next edge: state IDLE, `pulse_o` = 0, `busy_o` = 0, no `done_o`.
- Re-arming after a completed train or an abort requires `arm_i` to go low and then high again.
- Asserting `rst` mid-sequence drops `pulse_o` immediately (asynchronous).

## Timing
- Arm request sampled at edge j: `busy_o` = 1 from edge j.
- `trigger_i` first sampled high at edge k (default `SYNC_STAGES` = 2): `pulse_o` rises at edge k+3+delay.
- Each extra synchroniser stage adds one cycle.
- Pulse n falls `width` cycles after it rises. Pulse n+1 rises max(`spacing`, 1) cycles after pulse n falls.
- Total train length from first rise to last fall = N·width + (N−1)·max(spacing, 1).
- At the edge where the last pulse falls: `done_o` = 1 for one cycle, `busy_o` = 0, state IDLE.
- The earliest next arm request is sampled 2 edges after `arm_i` falls.
- Trigger glitches shorter than one clock period may be missed; that is acceptable.

## Test plan
- Arm with delay=10, width=4, N=1, spacing=0. Raise trigger at edge k. Required: `pulse_o` high for edges k+13..k+16, `done_o` at k+17, `busy_o` low at k+17.
- Arm with delay=0, width=2, N=3, spacing=5. Required: pulse rises at k+3, k+10, k+17, each 2 cycles wide; single `done_o` at k+19.
- spacing=0, width=1, N=4. Required: alternating 1/0/1/0/1/0/1, exactly 4 pulses, never merged.
- Arm with width=0, or with N=0. Required: stays IDLE, `busy_o` = 0, trigger produces no pulse.
- Deassert `arm_i` during the 2nd pulse of N=5. Required: `pulse_o` low next edge, no `done_o`, IDLE. A new trigger without a re-arm produces nothing.
- Trigger already high when armed, and extra trigger edges during the train. Required: no pulse until the next genuine rising edge in ARMED; edges mid-train ignored. Also assert `rst` mid-pulse: `pulse_o` = 0 immediately.
